if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the width of PC, PC+4 and instruction.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, giving the bubble instruction driven when the stage is empty.
REQ-003 SHALL have parameter CNT_W, default 16, giving the width of the drop counter.
REQ-004 SHALL use clock clk_i, reset rst_i; rst_i asynchronous, active-high.
REQ-005 SHALL have the ports below (clock and reset first):
  clk_i  in  1  clock
  rst_i  in  1  async active-high reset
  flush_i  in  1  discard all held and incoming beats
  in_valid_i  in  1  fetch beat present
  in_ready_o  out  1  stage can accept a beat
  pc_i, pc4_i, inst_i  in  XLEN each  fetch beat fields
  out_valid_o  out  1  decode beat present
  out_ready_i  in  1  decode consumes the beat
  pc_o, pc4_o, inst_o  out  XLEN each  decode beat fields
  drop_cnt_o  out  CNT_W  saturating count of beats discarded by flush

Function
REQ-006 SHALL accept a beat on a rising edge where in_valid_i && in_ready_o && !flush_i.
REQ-007 SHALL deliver a beat on a rising edge where out_valid_o && out_ready_i; delivered fields SHALL be bit-exact to those accepted, in order.
REQ-008 SHALL have a latency of one cycle: an accepted beat appears on the outputs in the next cycle.
REQ-009 SHALL sustain one beat per cycle while out_ready_i stays high.
REQ-010 SHALL hold the output fields and out_valid_o stable while out_valid_o && !out_ready_i.
REQ-011 SHALL drive inst_o = NOP_INST whenever out_valid_o = 0; pc_o and pc4_o SHALL then hold their last values (0 after reset).
REQ-012 SHALL give flush_i priority over every other event in its cycle:
  - all held entries are invalidated at the edge;
  - an incoming beat offered that cycle is discarded;
  - out_valid_o = 0 from the next cycle.
REQ-013 SHALL, on a flush edge, add to drop_cnt_o (held valid entries + 1 if in_valid_i && in_ready_o), saturating at 2^CNT_W-1.
REQ-014 SHALL not count a beat delivered downstream in the flush cycle as dropped: out_ready_i is honoured before the flush is applied.
REQ-015 SHALL use occupancy states EMPTY, BUSY (main register valid) and, in skid mode only, FULL (main + skid valid):
  - EMPTY -> BUSY on accept;
  - BUSY -> EMPTY on deliver with no accept;
  - BUSY -> FULL on accept while stalled;
  - FULL -> BUSY on deliver (skid moves to main);
  - any state -> EMPTY on flush.

Reset
REQ-016 SHALL, on rst_i, set state EMPTY, out_valid_o = 0, pc_o = 0, pc4_o = 0, inst_o = NOP_INST, drop_cnt_o = 0 and in_ready_o = 1, asynchronously.
REQ-017 SHALL, on reset asserted mid-transfer, discard all held beats without counting them; the first accept is permitted on the first edge after deassertion.

Configuration
REQ-018 SHALL compile the skid buffer when IF_ID_SKID_EN is defined:
  - in_ready_o is a register output, equal to (state != FULL), with no combinational path from out_ready_i.
REQ-019 SHALL, without IF_ID_SKID_EN, use a single register:
  - in_ready_o = !out_valid_o || out_ready_i, combinational;
  - FULL is unreachable;
  - held entries for REQ-013 are at most 1.

Structure
REQ-020 SHALL take the state encoding typedef (EMPTY/BUSY/FULL) and the default NOP constant from the shared CPU package.
REQ-021 SHALL contain at most one sub-module, if_id_entry (XLEN-wide pc/pc4/inst payload register with load enable), instantiated once for main and once for skid.

Verification
REQ-022 SHALL pass these directed scenarios:
  - Reset then idle -> out_valid_o = 0, inst_o = 32'h0000_0013, in_ready_o = 1, drop_cnt_o = 0.
  - Stream pc 0x0, 0x4, 0x8 with out_ready_i = 1 -> each appears one cycle later, pc4_o = pc+4, no bubbles.
  - Accept pc 0x100, hold out_ready_i = 0 for 3 cycles while offering 0x104:
    - skid mode: 0x104 accepted, then in_ready_o = 0;
    - non-skid mode: 0x104 stalled;
    - in both modes, release delivers 0x100 then 0x104.
  - Skid mode FULL, flush_i with in_valid_i = 1 -> drop_cnt_o += 2, out_valid_o = 0 next cycle, inst_o = NOP.
  - CNT_W = 2, four flushes of one held beat each -> drop_cnt_o = 3 (saturated).
  - rst_i pulsed asynchronously between edges while BUSY -> outputs at reset values immediately, drop_cnt_o = 0.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared CPU pipeline types and constants for the IF/ID stage
package if_id_stage_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} occ_e;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
endpackage

// File: rtl/if_id_entry.sv
// if_id_entry: pc/pc4/inst payload register with load enable
module if_id_entry #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc4_i,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic [XLEN-1:0] inst_o
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pc_o   <= '0;
      pc4_o  <= '0;
      inst_o <= '0;
    end else if (load_i) begin
      pc_o   <= pc_i;
      pc4_o  <= pc4_i;
      inst_o <= inst_i;
    end
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with flush and drop counter
// define IF_ID_SKID_EN for a two-entry skid buffer with registered in_ready_o
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_DEFAULT),
  parameter int              CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  pc4_i,
  input  logic [XLEN-1:0]  inst_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc4_o,
  output logic [XLEN-1:0]  inst_o,
  output logic [CNT_W-1:0] drop_cnt_o
);
  localparam int SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  occ_e state_q, state_d;
  logic accept, deliver, load_main;
  logic [XLEN-1:0] m_pc, m_pc4, m_inst, main_inst;
  logic [SW-1:0] drop_sum;
  logic [CNT_W-1:0] drop_d;
  assign out_valid_o = state_q != EMPTY;
  assign deliver = out_valid_o && out_ready_i;
  assign accept = in_valid_i && in_ready_o && !flush_i;
  assign inst_o = out_valid_o ? main_inst : NOP_INST;
  // a beat delivered in the flush cycle has left the stage and is not a drop
  assign drop_sum = SW'(drop_cnt_o) + SW'(out_valid_o) + SW'(state_q == FULL)
                  - SW'(deliver) + SW'(in_valid_i && in_ready_o);
  assign drop_d = !flush_i ? drop_cnt_o
                : drop_sum > SW'(CNT_MAX) ? CNT_MAX : drop_sum[CNT_W-1:0];
`ifdef IF_ID_SKID_EN
  logic load_skid, sel_skid, in_ready_q;
  logic [XLEN-1:0] skid_pc, skid_pc4, skid_inst;
  assign in_ready_o = in_ready_q;
  assign sel_skid = state_q == FULL;
  assign load_skid = accept && state_q == BUSY && !deliver;
  assign load_main = !flush_i && (sel_skid ? deliver : accept && (state_q == EMPTY || deliver));
  assign m_pc = sel_skid ? skid_pc : pc_i;
  assign m_pc4 = sel_skid ? skid_pc4 : pc4_i;
  assign m_inst = sel_skid ? skid_inst : inst_i;
  always_comb
    state_d = flush_i ? EMPTY
            : state_q == EMPTY ? (accept ? BUSY : EMPTY)
            : state_q == BUSY ? (accept && !deliver ? FULL : deliver && !accept ? EMPTY : BUSY)
            : (deliver ? BUSY : FULL);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) in_ready_q <= 1'b1;
    else in_ready_q <= state_d != FULL;
  if_id_entry #(.XLEN(XLEN)) u_skid (
    .clk_i, .rst_i, .load_i(load_skid),
    .pc_i, .pc4_i, .inst_i,
    .pc_o(skid_pc), .pc4_o(skid_pc4), .inst_o(skid_inst)
  );
`else
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign load_main = accept;
  assign m_pc = pc_i;
  assign m_pc4 = pc4_i;
  assign m_inst = inst_i;
  always_comb
    state_d = flush_i ? EMPTY : accept ? BUSY : deliver ? EMPTY : state_q;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q    <= EMPTY;
      drop_cnt_o <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_o <= drop_d;
    end
  if_id_entry #(.XLEN(XLEN)) u_main (
    .clk_i, .rst_i, .load_i(load_main),
    .pc_i(m_pc), .pc4_i(m_pc4), .inst_i(m_inst),
    .pc_o, .pc4_o, .inst_o(main_inst)
  );
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: scoreboard bench for if_id_stage (either build of IF_ID_SKID_EN)
`timescale 1ns/100ps
module tb_if_id_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  typedef struct {logic [31:0] pc, pc4, inst;} beat_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] pc = 0, pc4 = 0, inst = 0;
  logic in_ready_o, out_valid_o, rdy2, ov2;
  logic [31:0] pc_o, pc4_o, inst_o, pc2, pc42, inst2;
  logic [15:0] drop_cnt_o;
  logic [1:0] drop2;
  beat_t sb[$];
  int total = 0, bad = 0;
  int exp_drop = 0, exp_drop2 = 0;

  if_id_stage dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .pc_i(pc), .pc4_i(pc4), .inst_i(inst), .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .pc_o(pc_o), .pc4_o(pc4_o), .inst_o(inst_o), .drop_cnt_o(drop_cnt_o)
  );
  if_id_stage #(.CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy2),
    .pc_i(pc), .pc4_i(pc4), .inst_i(inst), .out_valid_o(ov2), .out_ready_i(out_ready),
    .pc_o(pc2), .pc4_o(pc42), .inst_o(inst2), .drop_cnt_o(drop2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst) begin
    beat_t b;
    logic exp_rdy;
    exp_rdy = SKID ? sb.size() < 2 : (sb.size() == 0 || out_ready);
    total++;
    if (out_valid_o !== (sb.size() != 0)) begin
      bad++;
      $display("FAIL sb_valid out_valid_o=%b required=%b", out_valid_o, sb.size() != 0);
    end
    total++;
    if (in_ready_o !== exp_rdy) begin
      bad++;
      $display("FAIL sb_ready in_ready_o=%b required=%b", in_ready_o, exp_rdy);
    end
    if (!out_valid_o) begin
      total++;
      if (inst_o !== NOP) begin
        bad++;
        $display("FAIL sb_bubble inst_o=%h required=%h", inst_o, NOP);
      end
    end
    if (out_valid_o && out_ready && sb.size() != 0) begin
      b = sb.pop_front();
      total++;
      if (pc_o !== b.pc || pc4_o !== b.pc4 || inst_o !== b.inst) begin
        bad++;
        $display("FAIL sb_beat got=%h/%h/%h required=%h/%h/%h", pc_o, pc4_o, inst_o, b.pc, b.pc4, b.inst);
      end
    end
    if (flush) begin
      exp_drop += sb.size() + ((in_valid && exp_rdy) ? 1 : 0);
      if (exp_drop > 65535) exp_drop = 65535;
      exp_drop2 += sb.size() + ((in_valid && exp_rdy) ? 1 : 0);
      if (exp_drop2 > 3) exp_drop2 = 3;
      sb.delete();
    end else if (in_valid && exp_rdy) sb.push_back('{pc, pc4, inst});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a);
    in_valid = 1; pc = a; pc4 = a + 4; inst = $urandom;
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    step();
    rst = 0;
    sb.delete(); exp_drop = 0; exp_drop2 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    total++;
    if (out_valid_o !== 0 || inst_o !== NOP || in_ready_o !== 1 || drop_cnt_o !== 0 || pc_o !== 0 || pc4_o !== 0) begin
      bad++;
      $display("FAIL reset v=%b inst=%h rdy=%b drop=%0d pc=%h pc4=%h required 0/%h/1/0/0/0",
               out_valid_o, inst_o, in_ready_o, drop_cnt_o, pc_o, pc4_o, NOP);
    end
  endtask

  task automatic test_stream();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      offer(32'(i * 4));
      step();
      total++;
      if (out_valid_o !== 1 || pc_o !== 32'(i * 4) || pc4_o !== 32'(i * 4 + 4)) begin
        bad++;
        $display("FAIL stream%0d v=%b pc=%h pc4=%h required 1/%h/%h", i, out_valid_o, pc_o, pc4_o, i * 4, i * 4 + 4);
      end
    end
    in_valid = 0;
    step();
    total++;
    if (out_valid_o !== 0) begin
      bad++;
      $display("FAIL stream_drain out_valid_o=%b required=0", out_valid_o);
    end
  endtask

  task automatic test_stall();
    logic took, r;
    took = 0;
    out_ready = 0;
    offer(32'h100);
    step();
    offer(32'h104);
    for (int i = 0; i < 3; i++) begin
      r = in_ready_o;
      step();
      if (r && in_valid) begin
        took = 1;
        in_valid = 0;
      end
      total++;
      if (pc_o !== 32'h100 || out_valid_o !== 1) begin
        bad++;
        $display("FAIL stall_hold%0d pc=%h v=%b required 100/1", i, pc_o, out_valid_o);
      end
    end
    total++;
    if (took !== SKID || in_ready_o !== 0) begin
      bad++;
      $display("FAIL stall_accept took=%b rdy=%b required %b/0", took, in_ready_o, SKID);
    end
    out_ready = 1;
    step();
    in_valid = 0;
    total++;
    if (out_valid_o !== 1 || pc_o !== 32'h104) begin
      bad++;
      $display("FAIL stall_release v=%b pc=%h required 1/104", out_valid_o, pc_o);
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 0;
    offer(32'h200);
    step();
    offer(32'h204);
    step();
    offer(32'h208);
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    total++;
    if (drop_cnt_o !== 16'(SKID ? 2 : 1) || out_valid_o !== 0 || inst_o !== NOP) begin
      bad++;
      $display("FAIL flush_full drop=%0d v=%b inst=%h required %0d/0/%h", drop_cnt_o, out_valid_o, inst_o, SKID ? 2 : 1, NOP);
    end
    offer(32'h300);
    step();
    out_ready = 1;
    offer(32'h304);
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    total++;
    if (drop_cnt_o !== 16'(SKID ? 3 : 2) || drop_cnt_o !== 16'(exp_drop) || out_valid_o !== 0) begin
      bad++;
      $display("FAIL flush_deliver drop=%0d v=%b required %0d/0", drop_cnt_o, out_valid_o, SKID ? 3 : 2);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      out_ready = 0;
      offer(32'h400 + 32'(i * 4));
      step();
      in_valid = 0; flush = 1;
      step();
      flush = 0;
    end
    total++;
    if (drop2 !== 2'd3 || drop_cnt_o !== 16'd4 || exp_drop2 !== 3) begin
      bad++;
      $display("FAIL saturate drop2=%0d drop=%0d required 3/4", drop2, drop_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    offer(32'h500);
    step();
    in_valid = 0;
    #1 rst = 1;
    #1;
    total++;
    if (out_valid_o !== 0 || pc_o !== 0 || pc4_o !== 0 || inst_o !== NOP || drop_cnt_o !== 0 || in_ready_o !== 1 || drop2 !== 0) begin
      bad++;
      $display("FAIL async_reset v=%b pc=%h pc4=%h inst=%h drop=%0d rdy=%b required 0/0/0/%h/0/1",
               out_valid_o, pc_o, pc4_o, inst_o, drop_cnt_o, in_ready_o, NOP);
    end
    rst = 0;
    sb.delete(); exp_drop = 0; exp_drop2 = 0;
    out_ready = 1;
    offer(32'h600);
    step();
    in_valid = 0;
    total++;
    if (out_valid_o !== 1 || pc_o !== 32'h600) begin
      bad++;
      $display("FAIL reset_first_accept v=%b pc=%h required 1/600", out_valid_o, pc_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      offer(32'h1000 + 32'(i * 4));
      out_ready = (i % 3) != 1;
      step();
      if (!in_ready_o && SKID) in_valid = 0;
    end
    in_valid = 0; out_ready = 1;
    repeat (4) step();
    total++;
    if (out_valid_o !== 0 || drop_cnt_o !== 16'(exp_drop)) begin
      bad++;
      $display("FAIL back_to_back_end v=%b drop=%0d required 0/%0d", out_valid_o, drop_cnt_o, exp_drop);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
